mc_ctrl_fsm: RTL and testbench

- Control FSM for the multi-cycle LoongArch core. Sequences the shared datapath (PC, IR, regfile, ALU, data SRAM port) through IF/ID/EXE/MEM/WB.
- Emits per-state register enables and SRAM request strobes. Holds the retire and cycle counters.
- Sits beside the datapath and takes decoded instruction-class flags from the ID decoder.

---
 rtl/mc_pkg.sv | 15 +
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_ctrl_fsm.sv | 140 ++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control FSM.
// Provides the state encoding and its width.
package mc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

endpackage

// File: rtl/mc_wait_timer.sv
// SRAM wait-limit timer shared by the fetch and data phases.
// Ports: clk, clr (restart count), busy (request unacked), expired (limit hit).
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(WAIT_LIMIT + 2);
  localparam bit EN = WAIT_LIMIT > 0;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] LAST =
    CW'(EN ? WAIT_LIMIT - 1 : 0);

  logic [CW-1:0] cnt;

  // Saturates at the limit so the count never wraps back.
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (busy && cnt != LIM)
      cnt <= cnt + 1'b1;
  end

  // Fires in the cycle whose edge brings the count to the limit.
  assign expired = EN && busy && (cnt == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Control FSM sequencing IF/ID/EXE/MEM/WB of the multi-cycle core.
// Ports: decoded class flags and SRAM acks in; enables, requests, counters out.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_load,
  input  logic               dec_store,
  input  logic               dec_gr_we,
  input  logic               inst_ack,
  input  logic               data_ack,
  output logic               inst_req,
  output logic               data_req,
  output logic               data_we,
  output logic               ir_we,
  output logic               opnd_we,
  output logic               alu_we,
  output logic               mdr_we,
  output logic               rf_we,
  output logic               pc_we,
  output logic               retire,
  output logic [STATE_W-1:0] state,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   instret,
  output logic [CNT_W-1:0]   cycles
);

  state_e cur, nxt;
  logic   busy, clr, expired;

  always_ff @(posedge clk) begin
    if (reset)
      cur <= S_IF;
    else
      cur <= nxt;
  end

  assign state = cur;

  // Strobes are gated by reset so an aborted
  // instruction never writes PC or regfile.
  always_comb begin
    nxt      = cur;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
    ir_we    = 1'b0;
    opnd_we  = 1'b0;
    alu_we   = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    if (!reset) begin
      unique case (cur)
        S_IF: begin
          inst_req = 1'b1;
          if (inst_ack) begin
            ir_we = 1'b1;
            nxt   = S_ID;
          end
        end
        S_ID: begin
          opnd_we = 1'b1;
          nxt     = S_EXE;
        end
        S_EXE: begin
          alu_we = 1'b1;
          if (dec_load || dec_store)
            nxt = S_MEM;
          else if (dec_gr_we)
            nxt = S_WB;
          else begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = S_IF;
          end
        end
        S_MEM: begin
          data_req = 1'b1;
          data_we  = dec_store & ~dec_load;
          if (data_ack) begin
            if (dec_load) begin
              mdr_we = 1'b1;
              nxt    = S_WB;
            end else begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = S_IF;
            end
          end
        end
        S_WB: begin
          rf_we  = dec_gr_we;
          pc_we  = 1'b1;
          retire = 1'b1;
          nxt    = S_IF;
        end
        default: nxt = S_IF;
      endcase
    end
  end

  assign busy = (cur == S_IF  && !inst_ack) ||
                (cur == S_MEM && !data_ack);

  // Restart the wait count on every entry into
  // a requesting state.
  assign clr = reset ||
               (nxt != cur &&
                (nxt == S_IF || nxt == S_MEM));

  mc_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_timer (
    .clk    (clk),
    .clr    (clr),
    .busy   (busy),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
      instret     <= '0;
      cycles      <= '0;
    end else begin
      if (expired)
        timeout_err <= 1'b1;
      if (retire)
        instret <= instret + 1'b1;
      cycles <= cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm.
// Directed scenarios plus randomized traffic against a phase-list model.
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 8;
  localparam int WL    = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dec_load = 1'b0, dec_store = 1'b0;
  logic dec_gr_we = 1'b0;
  logic inst_ack = 1'b0, data_ack = 1'b0;
  logic inst_req, data_req, data_we, ir_we;
  logic opnd_we, alu_we, mdr_we, rf_we;
  logic pc_we, retire, timeout_err;
  logic [2:0] state;
  logic [CNT_W-1:0] instret, cycles;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .CNT_W(CNT_W),
    .WAIT_LIMIT(WL)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_load(dec_load), .dec_store(dec_store),
    .dec_gr_we(dec_gr_we),
    .inst_ack(inst_ack), .data_ack(data_ack),
    .inst_req(inst_req), .data_req(data_req),
    .data_we(data_we), .ir_we(ir_we),
    .opnd_we(opnd_we), .alu_we(alu_we),
    .mdr_we(mdr_we), .rf_we(rf_we),
    .pc_we(pc_we), .retire(retire),
    .state(state), .timeout_err(timeout_err),
    .instret(instret), .cycles(cycles)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h",
               nm, act, exp);
    end
  endtask

  // Model: list of phases (0=IF..4=WB) the current
  // instruction walks through; rest added once fetched.
  int ph[$];
  int idx, lat, waits, wcnt;
  int m_instret, m_cycles;
  bit m_err, fresh;

  // Observations for directed checks.
  int o_cyc, o_rf, o_pc, o_pc_st, o_dreq;
  int o_dwe, o_mdr, o_ret, o_wb, o_errfirst;
  int st_q[$];

  function automatic void new_insn();
    ph = '{0};
    idx = 0; lat = 0; waits = 0; wcnt = 0;
    fresh = 1'b1;
  endfunction

  function automatic int base_lat();
    if (dec_load) return 5;
    if (dec_store) return 4;
    if (dec_gr_we) return 4;
    return 3;
  endfunction

  function automatic void clr_obs();
    o_cyc = 0; o_rf = 0; o_pc = 0; o_pc_st = -1;
    o_dreq = 0; o_dwe = 0; o_mdr = 0; o_ret = 0;
    o_wb = 0; o_errfirst = -1;
    st_q.delete();
  endfunction

  function automatic logic [9:0] strobes();
    return {inst_req, data_req, data_we, ir_we,
            opnd_we, alu_we, mdr_we, rf_we,
            pc_we, retire};
  endfunction

  // One clock: called at posedge+1 with inputs set.
  task automatic cyc();
    int  p;
    bit  ack, last, eret;
    logic [9:0] e;
    @(negedge clk); #1;
    if (reset) begin
      chk("rst_strobes", 32'(strobes()), 0);
      m_instret = 0; m_cycles = 0; m_err = 0;
      new_insn();
    end else begin
      p    = ph[idx];
      ack  = (p == 0) ? inst_ack :
             (p == 3) ? data_ack : 1'b1;
      last = (p != 0) && (idx == ph.size() - 1);
      eret = last && ack;
      e = {p == 0, p == 3,
           p == 3 && dec_store && !dec_load,
           p == 0 && ack, p == 1, p == 2,
           p == 3 && ack && !last,
           p == 4 && dec_gr_we,
           eret, eret};
      chk("strobes", 32'(strobes()), 32'(e));
      chk("state", 32'(state), p);
      chk("instret", 32'(instret), m_instret);
      chk("cycles", 32'(cycles), m_cycles);
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      st_q.push_back(int'(state));
      o_rf += rf_we; o_pc += pc_we;
      if (pc_we) o_pc_st = int'(state);
      o_dreq += data_req; o_dwe += data_we;
      o_mdr += mdr_we; o_ret += retire;
      o_wb += (state == 3'd4);
      if (timeout_err && o_errfirst < 0)
        o_errfirst = o_cyc;
      o_cyc++;
      m_cycles = (m_cycles + 1) % CMOD;
      lat++;
      if (!ack) begin
        wcnt++; waits++;
        if (wcnt == WL) m_err = 1'b1;
      end else begin
        wcnt = 0;
        if (p == 0) begin
          ph.push_back(1);
          ph.push_back(2);
          if (dec_load || dec_store) ph.push_back(3);
          if (dec_load || (!dec_store && dec_gr_we))
            ph.push_back(4);
        end
        if (eret) begin
          chk("latency", lat, base_lat() + waits);
          m_instret = (m_instret + 1) % CMOD;
          new_insn();
        end else
          idx++;
      end
    end
    @(posedge clk); #1;
  endtask

  int exp_st[4] = '{0, 1, 2, 4};

  initial begin
    clr_obs();
    new_insn();
    // Reset
    cyc();
    reset = 1'b0;
    chk("reset_state", 32'(state), 0);
    chk("reset_instret", 32'(instret), 0);
    chk("reset_cycles", 32'(cycles), 0);
    chk("reset_err", 32'(timeout_err), 0);

    // add.w, zero-wait
    dec_gr_we = 1'b1; inst_ack = 1'b1; data_ack = 1'b1;
    clr_obs();
    repeat (4) cyc();
    for (int i = 0; i < 4; i++)
      chk($sformatf("add_st%0d", i), st_q[i], exp_st[i]);
    chk("add_rf_cnt", o_rf, 1);
    chk("add_pc_state", o_pc_st, 4);
    chk("add_instret", 32'(instret), 1);
    chk("add_cycles", 32'(cycles), 4);

    // beq, acks tied high
    dec_gr_we = 1'b0;
    clr_obs();
    repeat (3) cyc();
    chk("beq_retire", o_ret, 1);
    chk("beq_rf_cnt", o_rf, 0);
    chk("beq_pc_cnt", o_pc, 1);
    chk("beq_pc_state", o_pc_st, 2);

    // ld.w, data_ack 2 cycles late
    dec_load = 1'b1; dec_gr_we = 1'b1;
    clr_obs();
    repeat (3) cyc();
    data_ack = 1'b0;
    repeat (2) cyc();
    data_ack = 1'b1;
    repeat (2) cyc();
    chk("ld_total", o_cyc, 7);
    chk("ld_dreq", o_dreq, 3);
    chk("ld_dwe", o_dwe, 0);
    chk("ld_mdr", o_mdr, 1);
    chk("ld_rf", o_rf, 1);
    chk("ld_retire", o_ret, 1);

    // st.w, one wait
    dec_load = 1'b0; dec_store = 1'b1; dec_gr_we = 1'b0;
    clr_obs();
    repeat (3) cyc();
    data_ack = 1'b0;
    cyc();
    data_ack = 1'b1;
    cyc();
    chk("st_dwe", o_dwe, 2);
    chk("st_rf", o_rf, 0);
    chk("st_wb", o_wb, 0);
    chk("st_retire", o_ret, 1);

    // fetch timeout
    dec_store = 1'b0; dec_gr_we = 1'b1;
    inst_ack = 1'b0;
    clr_obs();
    repeat (10) cyc();
    inst_ack = 1'b1;
    repeat (4) cyc();
    chk("to_first", o_errfirst, 4);
    chk("to_retire", o_ret, 1);
    chk("to_sticky", 32'(timeout_err), 1);

    // reset in MEM of a store
    reset = 1'b1; cyc(); reset = 1'b0;
    dec_gr_we = 1'b0; dec_store = 1'b1;
    data_ack = 1'b0;
    repeat (3) cyc();
    chk("abort_in_mem", 32'(state), 3);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("abort_state", 32'(state), 0);
    chk("abort_dreq", 32'(data_req), 0);
    chk("abort_retire", 32'(retire), 0);
    chk("abort_instret", 32'(instret), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      inst_ack = ($urandom_range(0, 2) != 0);
      data_ack = ($urandom_range(0, 2) != 0);
      if (fresh) begin
        {dec_load, dec_store, dec_gr_we} = 3'($urandom);
        fresh = 1'b0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
